// File: rtl/axis_mem_reader.sv
// axis_mem_reader
// ---------------
// Command-driven AXI-Stream source. One command names a start word address,
// a length in words and a first-beat user flag. The block reads that
// contiguous range from a synchronous single-port RAM, one word per cycle, and
// emits the words as a single AXI-Stream frame. Addresses wrap modulo
// 2**ADDR_WIDTH.
//
// Reads are throttled by a credit count: words held in the 2-entry output
// buffer plus the read still in flight. A read is only issued when its word is
// guaranteed a free slot on return. This lets the stream apply full
// backpressure without any word being dropped or duplicated.
//
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   cmd_addr/len/user command fields, accepted on cmd_valid && cmd_ready
//   cmd_valid/ready   command handshake (ready only while idle)
//   mem_en/addr       RAM read request
//   mem_rdata         RAM read data, valid one cycle after mem_en
//   out_axis_*        output stream (tdata, tvalid, tready, tuser, tlast)
//   busy              high while a frame is being read or drained
//   done              single-cycle pulse when a frame completes

module axis_mem_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_user,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,

    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic [DATA_WIDTH-1:0] out_axis_tdata,
    output logic                  out_axis_tvalid,
    input  logic                  out_axis_tready,
    output logic                  out_axis_tuser,
    output logic                  out_axis_tlast,

    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } state_t;

    state_t state;

    // Command context and read progress
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [LEN_WIDTH-1:0]  rd_count;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  user_q;

    // Sideband travelling alongside the outstanding RAM read
    logic                  inflight;
    logic                  inflight_user;
    logic                  inflight_last;

    // Two-entry output buffer; slot 0 is the head and drives the stream
    logic [1:0]            occupancy;
    logic [DATA_WIDTH-1:0] data0, data1;
    logic                  user0, user1;
    logic                  last0, last1;

    logic [1:0]            credit;
    logic                  handshake;
    logic                  issue;
    logic                  last_read;

    assign credit    = occupancy + {1'b0, inflight};
    assign handshake = (occupancy != 2'd0) && out_axis_tready;

    // A read may go out at full credit only if a word leaves the buffer in the
    // same cycle; otherwise the returning word would have nowhere to land.
    assign issue     = (state == READ) &&
                       ((credit < 2'd2) || ((credit == 2'd2) && handshake));
    assign last_read = (rd_count == (len_q - LEN_WIDTH'(1)));

    assign cmd_ready       = (state == IDLE);
    assign busy            = (state == READ) || (state == DRAIN);
    assign done            = (state == FINISH);
    assign mem_en          = issue;
    assign mem_addr        = rd_addr;
    assign out_axis_tvalid = (occupancy != 2'd0);
    assign out_axis_tdata  = data0;
    assign out_axis_tuser  = out_axis_tvalid && user0;
    assign out_axis_tlast  = out_axis_tvalid && last0;

    // Frame control. A zero-length command skips straight to FINISH so it
    // still produces a done pulse. DRAIN ends on the tlast handshake, which
    // can only belong to the current frame since the buffer holds no other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_addr  <= '0;
            rd_count <= '0;
            len_q    <= '0;
            user_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rd_addr  <= cmd_addr;
                        len_q    <= cmd_len;
                        user_q   <= cmd_user;
                        rd_count <= '0;
                        state    <= (cmd_len == '0) ? FINISH : READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_addr  <= rd_addr + ADDR_WIDTH'(1);
                        rd_count <= rd_count + LEN_WIDTH'(1);
                        if (last_read) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake && out_axis_tlast) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tag each read with its frame position so the buffer can mark the first
    // and last beats when the data returns one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_user <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_user <= (rd_count == '0) && user_q;
            inflight_last <= last_read;
        end
    end

    // Output buffer. Returning data goes to the head when it is empty or is
    // being consumed, otherwise to slot 1. Credit gating means a push never
    // arrives while both slots are full and none is leaving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= 2'd0;
            data0     <= '0;
            data1     <= '0;
            user0     <= 1'b0;
            user1     <= 1'b0;
            last0     <= 1'b0;
            last1     <= 1'b0;
        end else begin
            case (occupancy)
                2'd0: begin
                    if (inflight) begin
                        data0     <= mem_rdata;
                        user0     <= inflight_user;
                        last0     <= inflight_last;
                        occupancy <= 2'd1;
                    end
                end
                2'd1: begin
                    if (inflight && handshake) begin
                        data0 <= mem_rdata;
                        user0 <= inflight_user;
                        last0 <= inflight_last;
                    end else if (inflight) begin
                        data1     <= mem_rdata;
                        user1     <= inflight_user;
                        last1     <= inflight_last;
                        occupancy <= 2'd2;
                    end else if (handshake) begin
                        occupancy <= 2'd0;
                    end
                end
                2'd2: begin
                    if (handshake) begin
                        data0 <= data1;
                        user0 <= user1;
                        last0 <= last1;
                        if (inflight) begin
                            data1 <= mem_rdata;
                            user1 <= inflight_user;
                            last1 <= inflight_last;
                        end else begin
                            occupancy <= 2'd1;
                        end
                    end
                end
                default: begin
                    occupancy <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_mem_reader.sv
// Testbench for axis_mem_reader: directed commands against a RAM model
// holding ram[i] = i, with a negedge monitor logging reads, beats and done
// pulses for the checks in the main sequence.

module tb_axis_mem_reader;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          cmd_user;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] out_axis_tdata;
    logic          out_axis_tvalid;
    logic          out_axis_tready = 1'b0;
    logic          out_axis_tuser;
    logic          out_axis_tlast;
    logic          busy;
    logic          done;

    axis_mem_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_user(cmd_user),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_axis_tdata(out_axis_tdata), .out_axis_tvalid(out_axis_tvalid),
        .out_axis_tready(out_axis_tready), .out_axis_tuser(out_axis_tuser),
        .out_axis_tlast(out_axis_tlast), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model, one cycle read latency
    logic [DW-1:0] ram [0:2**AW-1];
    initial for (int i = 0; i < 2**AW; i++) ram[i] = DW'(i);
    always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // tready source: a fixed level, or the backpressure pattern
    bit treadyLevel = 1'b1;
    bit bpMode = 1'b0;
    int bpIdx = 0;
    bit bpPattern [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    always @(posedge clk) begin
        #1;
        if (bpMode) begin
            out_axis_tready = (bpIdx < 7) ? bpPattern[bpIdx] : 1'($urandom_range(0, 1));
            bpIdx++;
        end else begin
            out_axis_tready = treadyLevel;
            bpIdx = 0;
        end
    end

    // Monitor logs
    logic [DW-1:0] beatData [$];
    bit            beatUser [$];
    bit            beatLast [$];
    int            beatCyc  [$];
    logic [AW-1:0] addrLog  [$];
    int            addrCyc  [$];
    int            doneCyc  [$];
    int            riseCyc  [$];
    int            issued = 0, consumed = 0;
    int            creditErr = 0, stabErr = 0, busyCount = 0;
    bit            holdPending = 1'b0, prevValid = 1'b0, hs;
    logic [DW+1:0] held;

    // Sample everything on the falling edge, away from the DUT's active edge.
    // issued - consumed is the DUT's credit: every issued read becomes a beat.
    always @(negedge clk) begin
        if (rst) begin
            issued = 0; consumed = 0; holdPending = 1'b0; prevValid = 1'b0;
        end else begin
            hs = out_axis_tvalid && out_axis_tready;
            if (mem_en) begin
                addrLog.push_back(mem_addr);
                addrCyc.push_back(cyc);
                if ((issued - consumed) > 2 || ((issued - consumed) == 2 && !hs)) creditErr++;
            end
            if (holdPending && (!out_axis_tvalid ||
                {out_axis_tdata, out_axis_tuser, out_axis_tlast} != held)) stabErr++;
            holdPending = out_axis_tvalid && !out_axis_tready;
            held = {out_axis_tdata, out_axis_tuser, out_axis_tlast};
            if (out_axis_tvalid && !prevValid) riseCyc.push_back(cyc);
            prevValid = out_axis_tvalid;
            if (hs) begin
                beatData.push_back(out_axis_tdata);
                beatUser.push_back(out_axis_tuser);
                beatLast.push_back(out_axis_tlast);
                beatCyc.push_back(cyc);
            end
            if (done) doneCyc.push_back(cyc);
            if (busy) busyCount++;
            if (mem_en) issued++;
            if (hs) consumed++;
        end
    end

    int assertCount = 0;
    int failCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present a command and wait (bounded) for its handshake. Returns just
    // after the accepting edge; optionally keeps cmd_valid high.
    task automatic applyStimulus(input logic [AW-1:0] a, input logic [LW-1:0] l,
                                 input bit u, input bit dropValid, output int acceptCyc);
        bit accepted = 1'b0;
        cmd_addr = a; cmd_len = l; cmd_user = u; cmd_valid = 1'b1;
        acceptCyc = -1;
        for (int i = 0; i < 300 && !accepted; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1'b1;
                acceptCyc = cyc;
            end
        end
        if (!accepted) begin
            checkOutput("cmd accept timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (dropValid) cmd_valid = 1'b0;
        end
    endtask

    task automatic waitDones(input int target);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (doneCyc.size() >= target) seen = 1'b1;
        end
        if (!seen) checkOutput("done timeout", 32'd0, 32'd1);
        repeat (5) @(posedge clk);
        #2;
    endtask

    task automatic checkFrame(input string tag, input int bIdx, input int aIdx,
                              input logic [AW-1:0] a, input int n, input bit u,
                              input bit consecutive);
        logic [AW-1:0] ea;
        for (int i = 0; i < n; i++) begin
            ea = a + AW'(i);
            if (aIdx + i < addrLog.size()) begin
                checkOutput($sformatf("%s addr%0d", tag, i), 32'(addrLog[aIdx+i]), 32'(ea));
                if (consecutive)
                    checkOutput($sformatf("%s addr%0d cycle", tag, i),
                                32'(addrCyc[aIdx+i]), 32'(addrCyc[aIdx] + i));
            end
            if (bIdx + i < beatData.size()) begin
                checkOutput($sformatf("%s beat%0d data", tag, i), beatData[bIdx+i], 32'(ea));
                checkOutput($sformatf("%s beat%0d user", tag, i), 32'(beatUser[bIdx+i]),
                            32'((i == 0) ? u : 1'b0));
                checkOutput($sformatf("%s beat%0d last", tag, i), 32'(beatLast[bIdx+i]),
                            32'(i == n - 1));
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int t, t2, bb, ab, db, rb, busyBase, lastCount;
    bit reached;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_user = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset mem_en", 32'(mem_en), 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset tvalid", 32'(out_axis_tvalid), 32'd0);
        checkOutput("reset tuser", 32'(out_axis_tuser), 32'd0);
        checkOutput("reset tlast", 32'(out_axis_tlast), 32'd0);
        checkOutput("reset tdata", out_axis_tdata, 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] basic frame");
        bb = beatData.size(); ab = addrLog.size(); db = doneCyc.size(); rb = riseCyc.size();
        applyStimulus(11'h010, 16'd4, 1'b1, 1'b1, t);
        waitDones(db + 1);
        checkOutput("basic beats", 32'(beatData.size() - bb), 32'd4);
        checkOutput("basic reads", 32'(addrLog.size() - ab), 32'd4);
        checkOutput("basic dones", 32'(doneCyc.size() - db), 32'd1);
        checkFrame("basic", bb, ab, 11'h010, 4, 1'b1, 1'b1);
        if (addrLog.size() > ab) checkOutput("basic mem_en latency", 32'(addrCyc[ab]), 32'(t + 1));
        if (riseCyc.size() > rb) checkOutput("basic tvalid latency", 32'(riseCyc[rb]), 32'(t + 3));
        if (beatData.size() >= bb + 4 && doneCyc.size() > db)
            checkOutput("basic done timing", 32'(doneCyc[db]), 32'(beatCyc[bb+3] + 1));

        $display("[TB] address wrap");
        bb = beatData.size(); ab = addrLog.size(); db = doneCyc.size();
        applyStimulus(11'h7FE, 16'd4, 1'b0, 1'b1, t);
        waitDones(db + 1);
        checkOutput("wrap beats", 32'(beatData.size() - bb), 32'd4);
        checkFrame("wrap", bb, ab, 11'h7FE, 4, 1'b0, 1'b1);

        $display("[TB] backpressure");
        bb = beatData.size(); ab = addrLog.size(); db = doneCyc.size();
        bpMode = 1'b1;
        applyStimulus(11'h200, 16'd8, 1'b1, 1'b1, t);
        waitDones(db + 1);
        bpMode = 1'b0;
        checkOutput("bp beats", 32'(beatData.size() - bb), 32'd8);
        checkOutput("bp reads", 32'(addrLog.size() - ab), 32'd8);
        checkFrame("bp", bb, ab, 11'h200, 8, 1'b1, 1'b0);
        checkOutput("bp credit violations", 32'(creditErr), 32'd0);
        checkOutput("bp stability violations", 32'(stabErr), 32'd0);

        $display("[TB] zero length");
        bb = beatData.size(); db = doneCyc.size(); busyBase = busyCount;
        applyStimulus(11'h055, 16'd0, 1'b1, 1'b1, t);
        @(negedge clk);
        checkOutput("len0 finish cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("len0 finish done", 32'(done), 32'd1);
        @(negedge clk);
        checkOutput("len0 idle cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("len0 idle done", 32'(done), 32'd0);
        repeat (4) @(posedge clk);
        #2;
        checkOutput("len0 beats", 32'(beatData.size() - bb), 32'd0);
        checkOutput("len0 busy cycles", 32'(busyCount - busyBase), 32'd0);
        checkOutput("len0 dones", 32'(doneCyc.size() - db), 32'd1);
        if (doneCyc.size() > db) checkOutput("len0 done timing", 32'(doneCyc[db]), 32'(t + 1));

        $display("[TB] single beat");
        bb = beatData.size(); ab = addrLog.size(); db = doneCyc.size();
        applyStimulus(11'h005, 16'd1, 1'b1, 1'b1, t);
        waitDones(db + 1);
        checkOutput("len1 beats", 32'(beatData.size() - bb), 32'd1);
        checkFrame("len1", bb, ab, 11'h005, 1, 1'b1, 1'b1);

        $display("[TB] back-to-back");
        bb = beatData.size(); ab = addrLog.size(); db = doneCyc.size();
        applyStimulus(11'h020, 16'd3, 1'b1, 1'b0, t);
        applyStimulus(11'h040, 16'd2, 1'b1, 1'b1, t2);
        waitDones(db + 2);
        checkOutput("b2b beats", 32'(beatData.size() - bb), 32'd5);
        checkOutput("b2b dones", 32'(doneCyc.size() - db), 32'd2);
        checkFrame("b2b first", bb, ab, 11'h020, 3, 1'b1, 1'b1);
        checkFrame("b2b second", bb + 3, ab + 3, 11'h040, 2, 1'b1, 1'b1);
        if (doneCyc.size() > db) checkOutput("b2b accept timing", 32'(t2), 32'(doneCyc[db] + 1));
        if (doneCyc.size() > db && beatData.size() > bb + 3)
            checkOutput("b2b no interleave", 32'(beatCyc[bb+3] > doneCyc[db]), 32'd1);

        $display("[TB] reset mid-frame");
        bb = beatData.size(); db = doneCyc.size();
        applyStimulus(11'h100, 16'd6, 1'b1, 1'b1, t);
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(posedge clk);
            #2;
            if (beatData.size() - bb >= 2) reached = 1'b1;
        end
        checkOutput("midrst two beats seen", 32'(reached), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst tvalid", 32'(out_axis_tvalid), 32'd0);
        checkOutput("midrst tlast", 32'(out_axis_tlast), 32'd0);
        checkOutput("midrst tuser", 32'(out_axis_tuser), 32'd0);
        checkOutput("midrst tdata", out_axis_tdata, 32'd0);
        checkOutput("midrst busy", 32'(busy), 32'd0);
        checkOutput("midrst done", 32'(done), 32'd0);
        checkOutput("midrst mem_en", 32'(mem_en), 32'd0);
        checkOutput("midrst mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("midrst cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        lastCount = 0;
        for (int i = bb; i < beatData.size(); i++) lastCount += int'(beatLast[i]);
        checkOutput("midrst no tlast", 32'(lastCount), 32'd0);
        checkOutput("midrst no done", 32'(doneCyc.size() - db), 32'd0);
        bb = beatData.size(); ab = addrLog.size(); db = doneCyc.size();
        applyStimulus(11'h030, 16'd2, 1'b0, 1'b1, t);
        waitDones(db + 1);
        checkOutput("post-reset beats", 32'(beatData.size() - bb), 32'd2);
        checkOutput("post-reset dones", 32'(doneCyc.size() - db), 32'd1);
        checkFrame("post-reset", bb, ab, 11'h030, 2, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/axis_mem_reader.md
Name: axis_mem_reader

Overview:
- Command-driven AXI-Stream source. Reads a contiguous word range from a synchronous single-port RAM and emits it as one AXI-Stream frame.
- Feeds the input side of the stream FIFOs in accelerator datapaths.
- A one-word-per-cycle read engine with credit-based flow control toward a 2-entry output buffer. Full backpressure on the output without dropping or duplicating words.

Parameters:
- DATA_WIDTH, 32, width of memory word and out_axis_tdata.
- ADDR_WIDTH, 11, memory address width; addresses wrap modulo 2**ADDR_WIDTH.
- LEN_WIDTH, 16, width of command length field (in words).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_addr  in  ADDR_WIDTH  start word address.
- cmd_len  in  LEN_WIDTH  frame length in words; 0 = empty command.
- cmd_user  in  1  value driven on tuser of the first beat.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- mem_en  out  1  RAM read enable.
- mem_addr  out  ADDR_WIDTH  RAM read address.
- mem_rdata  in  DATA_WIDTH  RAM data, valid exactly 1 cycle after mem_en.
- out_axis_tdata  out  DATA_WIDTH  stream data.
- out_axis_tvalid  out  1  stream valid.
- out_axis_tready  in  1  stream ready.
- out_axis_tuser  out  1  cmd_user on the first beat of the frame, 0 otherwise.
- out_axis_tlast  out  1  high on the final beat of the frame.
- busy  out  1  high from command accept until frame completion.
- done  out  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (async assert; sync-style release acceptable): state=IDLE, all counters=0, buffer empty.
  - Outputs after reset: cmd_ready=1, mem_en=0, mem_addr=0, out_axis_tvalid=0, out_axis_tuser=0, out_axis_tlast=0, out_axis_tdata=0, busy=0, done=0.
- States:
  - IDLE: cmd_ready=1. On handshake, latch addr, len and user.
    - len>0: go to READ.
    - len==0: go to FINISH; emit no beats.
  - READ: issue one read per cycle while credit allows. After the len-th read is issued, go to DRAIN.
  - DRAIN: no reads. Wait for the handshake on the tlast beat, then go to FINISH.
  - FINISH: done=1 for this single cycle, busy=0, then go to IDLE. cmd_ready=0 here; the next command is accepted no earlier than the following cycle.
- busy=1 in READ and DRAIN; cmd_ready=0 in every state except IDLE.
- Flow control:
  - Credit = buffer_occupancy + reads_in_flight, where reads_in_flight is 0 or 1.
  - mem_en is asserted only when credit < 2, or when credit == 2 and an output handshake occurs this cycle. The buffer therefore never overflows.
  - Returned data is written into the 2-entry buffer, which drives out_axis_*.
- Throughput: with out_axis_tready held high, one beat per cycle, no bubbles after the first beat.
- Latency: command handshake at cycle T → mem_en at T+1 → first out_axis_tvalid at T+3.
- AXIS rules:
  - Once tvalid is high, tdata/tuser/tlast are held stable and tvalid stays high until the handshake.
  - tvalid does not depend combinationally on tready.
- Address: mem_addr = cmd_addr + n (mod 2**ADDR_WIDTH) for the n-th read; wrap from 2**ADDR_WIDTH-1 to 0 is silent.
- Length: internal word counters are LEN_WIDTH wide; the maximum frame is 2**LEN_WIDTH-1 words.
- tlast is asserted on beat number len-1. For len==1, the single beat carries both tuser=cmd_user and tlast=1.
- Reset mid-frame: the frame is abandoned immediately.
  - tvalid drops in the reset cycle, no tlast is ever produced, and no done pulse is produced.
  - Any read still in flight is discarded.

Test Plan:
- Basic frame: reset; cmd addr=0x010, len=4, user=1, tready=1; RAM[i]=i.
  - Required: mem_addr 0x010..0x013 on consecutive cycles.
  - Required: beats 0x10,0x11,0x12,0x13 with tuser=1,0,0,0 and tlast=0,0,0,1, first tvalid at T+3.
  - Required: done pulses one cycle after the last handshake.
- Wrap: ADDR_WIDTH=11, cmd addr=0x7FE, len=4 → mem_addr 0x7FE,0x7FF,0x000,0x001; data order preserved.
- Backpressure: len=8; tready toggles 1,0,0,1,0,1,1,… with a random pattern.
  - Required: exactly 8 beats in order, no duplicates or drops, tdata stable while tvalid && !tready.
  - Required: mem_en never issued when credit==2 without a same-cycle handshake.
- Edge lengths:
  - len=0 → no tvalid; busy stays 0; done pulses one cycle after accept; cmd_ready low for exactly that one FINISH cycle.
  - len=1 → single beat with tuser=cmd_user, tlast=1.
- Back-to-back: two commands presented continuously (len=3 then len=2) → second accepted 1 cycle after the first done; frames are not interleaved and each has its own tuser and tlast.
- Reset mid-frame: assert rst after 2 of 6 beats → outputs return to their reset values asynchronously.
  - Required: a new cmd len=2 after release produces exactly 2 beats and a single done pulse.
